// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave exposing C_NUM_REGS byte-writable 32-bit control registers
// Optional OPB_REG_COMMIT_EN: shadow registers plus a commit register at index C_NUM_REGS
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h01003400,
  parameter logic [31:0] C_HIGHADDR    = 32'h010034FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
  parameter string       C_FAMILY      = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_we
);

`ifdef OPB_REG_COMMIT_EN
  localparam int N_SLOTS = C_NUM_REGS + 1;
`else
  localparam int N_SLOTS = C_NUM_REGS;
`endif
  localparam longint WIN_BYTES = longint'(C_HIGHADDR) - longint'(C_BASEADDR) + 64'sd1;
  localparam int SEL_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [29:0] NUM_REGS_W = 30'(C_NUM_REGS);

  if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 64 ||
      longint'(N_SLOTS) * 64'sd4 > WIN_BYTES || C_FAMILY == "") begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [31:0] abus, offset, rdata, be_mask;
  logic [29:0] word_idx;
  logic        hit, wr_go;
  logic        unused_sig;

  logic [SEL_W-1:0] sel_q;
  logic             in_range_q, rnw_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [C_NUM_REGS-1:0] we_nxt;
  logic [31:0]      shadow [C_NUM_REGS];

  assign abus     = OPB_ABus;
  assign offset   = abus - C_BASEADDR;
  assign word_idx = offset[31:2];
  assign hit      = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign unused_sig = ^{OPB_seqAddr, offset[1:0]};

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Ack is masked by reset so a reset landing in the ACK cycle swallows the transfer.
  always_comb begin
    state_nxt  = state;
    Sl_xferAck = 1'b0;
    Sl_DBus    = '0;
    case (state)
      S_IDLE: if (hit) state_nxt = S_ACK;
      S_ACK: begin
        state_nxt  = S_WAIT;
        Sl_xferAck = !OPB_Rst;
        if (!OPB_Rst && rnw_q && in_range_q) Sl_DBus = rdata;
      end
      S_WAIT: if (!OPB_select) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef OPB_REG_COMMIT_EN
  logic        commit_q, commit_go;
  logic [31:0] out_q [C_NUM_REGS];
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      sel_q      <= '0;
      in_range_q <= 1'b0;
      rnw_q      <= 1'b1;
      wdata_q    <= '0;
      be_q       <= '0;
`ifdef OPB_REG_COMMIT_EN
      commit_q   <= 1'b0;
`endif
    end else if (state == S_IDLE && hit) begin
      sel_q      <= offset[SEL_W+1:2];
      in_range_q <= (word_idx < NUM_REGS_W);
      rnw_q      <= OPB_RNW;
      wdata_q    <= OPB_DBus;
      be_q       <= OPB_BE;
`ifdef OPB_REG_COMMIT_EN
      commit_q   <= (word_idx == NUM_REGS_W);
`endif
    end
  end

  // be_q[3] is OPB_BE[0], which covers the most significant byte.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{be_q[b]}};
  end

  assign wr_go = (state == S_ACK) && !rnw_q && in_range_q;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (sel_q == SEL_W'(i)) rdata = shadow[i];
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) shadow[i] <= C_RESET_VALUE;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++)
        if (wr_go && sel_q == SEL_W'(i))
          shadow[i] <= (shadow[i] & ~be_mask) | (wdata_q & be_mask);
    end
  end

`ifdef OPB_REG_COMMIT_EN
  assign commit_go = (state == S_ACK) && !rnw_q && commit_q && be_q[0] && wdata_q[0];

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) out_q[i] <= C_RESET_VALUE;
    end else if (commit_go) begin
      for (int i = 0; i < C_NUM_REGS; i++) out_q[i] <= shadow[i];
    end
  end

  always_comb begin
    we_nxt = '0;
    if (commit_go) we_nxt = '1;
    for (int i = 0; i < C_NUM_REGS; i++) user_data_out[32*i +: 32] = out_q[i];
  end
`else
  always_comb begin
    we_nxt = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_go && sel_q == SEL_W'(i)) we_nxt[i] = 1'b1;
      user_data_out[32*i +: 32] = shadow[i];
    end
  end
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) user_we <= '0;
    else         user_we <= we_nxt;
  end

endmodule
